// File: rtl/accelerator_top_sequencer.sv
// accelerator_top_sequencer: streams W/B/X operands into an accelerator, buffers Y results in a FIFO for the result stream; CLK/RST(sync, low) clock/reset, CMD_* job control, S_* operand in, M_* result out, ACC_* accelerator side
module accelerator_top_sequencer #(
  parameter int DATA_SIZE  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_START,
  input  logic                 CMD_ABORT,
  output logic                 CMD_BUSY,
  output logic                 CMD_DONE,
  output logic                 CMD_ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_X_IN,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic [DATA_SIZE-1:0] SIZE_Y_IN,
  input  logic [DATA_SIZE-1:0] S_DATA,
  input  logic                 S_VALID,
  output logic                 S_READY,
  output logic [DATA_SIZE-1:0] M_DATA,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic                 ACC_START,
  input  logic                 ACC_READY,
  output logic                 ACC_W_IN_L_ENABLE,
  output logic                 ACC_W_IN_X_ENABLE,
  output logic                 ACC_B_IN_ENABLE,
  output logic                 ACC_X_IN_ENABLE,
  output logic [DATA_SIZE-1:0] ACC_W_IN,
  output logic [DATA_SIZE-1:0] ACC_B_IN,
  output logic [DATA_SIZE-1:0] ACC_X_IN,
  input  logic                 ACC_Y_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] ACC_Y_OUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, LOAD_X, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_SIZE-1:0] sx_q, sl_q, sy_q, j_q, i_q, y_q;
  logic [DATA_SIZE-1:0] w_data_q, b_data_q, x_data_q;
  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic seen_q, err_q, s_ready_q, acc_start_q, wl_q, wx_q, b_q, x_q;
  logic beat, launch, abort, j_end, i_end, b_end, last, zero;
  logic empty, full, pop, push_req, push, ovf;
  assign launch   = state_q == IDLE && CMD_START;
  assign abort    = state_q != IDLE && CMD_ABORT;
  assign beat     = s_ready_q && S_VALID && !CMD_ABORT;
  assign j_end    = j_q == sx_q - ONE;
  assign i_end    = i_q == sl_q - ONE;
  assign b_end    = j_q == sl_q - ONE;
  assign last     = beat && (state_q == LOAD_W ? j_end && i_end : state_q == LOAD_B ? b_end : j_end);
  assign zero     = sx_q == '0 || sl_q == '0;
  assign empty    = wp_q == rp_q;
  assign full     = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign pop      = !empty && M_READY;
  assign push_req = state_q == RUN && ACC_Y_OUT_ENABLE;
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = CMD_START ? LOAD_W : IDLE;
      LOAD_W:  state_d = zero ? DONE : last ? LOAD_B : LOAD_W;
      LOAD_B:  state_d = last ? LOAD_X : LOAD_B;
      LOAD_X:  state_d = last ? RUN : LOAD_X;
      RUN:     state_d = seen_q && y_q == sy_q ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_comb begin
    CMD_BUSY          = RST && state_q != IDLE;
    CMD_DONE          = RST && state_q == DONE && !CMD_ABORT;
    CMD_ERROR         = RST && err_q;
    S_READY           = RST && s_ready_q;
    M_VALID           = RST && !empty;
    M_DATA            = RST ? mem_q[rp_q[AW-1:0]] : '0;
    ACC_START         = RST && acc_start_q;
    ACC_W_IN_L_ENABLE = RST && wl_q;
    ACC_W_IN_X_ENABLE = RST && wx_q;
    ACC_B_IN_ENABLE   = RST && b_q;
    ACC_X_IN_ENABLE   = RST && x_q;
    ACC_W_IN          = RST ? w_data_q : '0;
    ACC_B_IN          = RST ? b_data_q : '0;
    ACC_X_IN          = RST ? x_data_q : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      {sx_q, sl_q, sy_q, j_q, i_q, y_q} <= '0;
      {w_data_q, b_data_q, x_data_q} <= '0;
      {seen_q, err_q, s_ready_q, acc_start_q, wl_q, wx_q, b_q, x_q} <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (launch) begin
        sx_q <= SIZE_X_IN;
        sl_q <= SIZE_L_IN;
        sy_q <= SIZE_Y_IN;
      end
      // ready only once a phase has settled, giving a one-cycle gap at each phase entry
      s_ready_q   <= state_d == state_q && (state_q == LOAD_W || state_q == LOAD_B || state_q == LOAD_X);
      acc_start_q <= state_d == RUN && state_q != RUN;
      wx_q        <= beat && state_q == LOAD_W;
      wl_q        <= beat && state_q == LOAD_W && j_end;
      b_q         <= beat && state_q == LOAD_B;
      x_q         <= beat && state_q == LOAD_X;
      if (beat && state_q == LOAD_W) w_data_q <= S_DATA;
      if (beat && state_q == LOAD_B) b_data_q <= S_DATA;
      if (beat && state_q == LOAD_X) x_data_q <= S_DATA;
      j_q    <= launch ? '0 : beat ? ((state_q == LOAD_B ? b_end : j_end) ? '0 : j_q + ONE) : j_q;
      i_q    <= launch ? '0 : beat && state_q == LOAD_W && j_end ? (i_end ? '0 : i_q + ONE) : i_q;
      y_q    <= launch ? '0 : state_q == RUN && pop ? y_q + ONE : y_q;
      seen_q <= launch ? 1'b0 : seen_q | (state_q == RUN && !acc_start_q && ACC_READY);
      err_q  <= launch ? 1'b0 : err_q | (state_q == LOAD_W && zero) | ovf;
      wp_q   <= abort ? '0 : wp_q + {{AW{1'b0}}, push};
      rp_q   <= abort ? '0 : rp_q + {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q[AW-1:0]] <= ACC_Y_OUT;
  end
endmodule

// File: tb/tb_accelerator_top_sequencer.sv
// tb_accelerator_top_sequencer: scoreboard bench for accelerator_top_sequencer
module tb_accelerator_top_sequencer;
  localparam int DW = 64;
  logic CLK, RST, CMD_START, CMD_ABORT, CMD_BUSY, CMD_DONE, CMD_ERROR;
  logic [DW-1:0] SIZE_X_IN, SIZE_L_IN, SIZE_Y_IN, S_DATA, M_DATA;
  logic S_VALID, S_READY, M_VALID, M_READY, ACC_START, ACC_READY;
  logic ACC_W_IN_L_ENABLE, ACC_W_IN_X_ENABLE, ACC_B_IN_ENABLE, ACC_X_IN_ENABLE, ACC_Y_OUT_ENABLE;
  logic [DW-1:0] ACC_W_IN, ACC_B_IN, ACC_X_IN, ACC_Y_OUT;
  accelerator_top_sequencer #(.DATA_SIZE(DW), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
    .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_ERROR(CMD_ERROR),
    .SIZE_X_IN(SIZE_X_IN), .SIZE_L_IN(SIZE_L_IN), .SIZE_Y_IN(SIZE_Y_IN),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .ACC_START(ACC_START), .ACC_READY(ACC_READY),
    .ACC_W_IN_L_ENABLE(ACC_W_IN_L_ENABLE), .ACC_W_IN_X_ENABLE(ACC_W_IN_X_ENABLE),
    .ACC_B_IN_ENABLE(ACC_B_IN_ENABLE), .ACC_X_IN_ENABLE(ACC_X_IN_ENABLE),
    .ACC_W_IN(ACC_W_IN), .ACC_B_IN(ACC_B_IN), .ACC_X_IN(ACC_X_IN),
    .ACC_Y_OUT_ENABLE(ACC_Y_OUT_ENABLE), .ACC_Y_OUT(ACC_Y_OUT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0, start_cnt = 0, srdy_cnt = 0;
  logic [DW-1:0] beats [$];
  logic [DW-1:0] exp_w [$], exp_b [$], exp_x [$], exp_m [$];
  bit exp_wl [$], exp_done [$];
  logic any_out;
  assign any_out = |{CMD_BUSY, CMD_DONE, CMD_ERROR, S_READY, M_VALID, ACC_START, ACC_W_IN_L_ENABLE,
                     ACC_W_IN_X_ENABLE, ACC_B_IN_ENABLE, ACC_X_IN_ENABLE, M_DATA, ACC_W_IN, ACC_B_IN, ACC_X_IN};
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic unexp(input string name, input logic [DW-1:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output %0h, expected none", name, act);
  endtask
  always @(negedge CLK) if (RST) begin
    if (ACC_W_IN_X_ENABLE) begin
      if (exp_w.size() == 0) unexp("w_strobe", ACC_W_IN);
      else begin
        chk("w_data", ACC_W_IN, exp_w.pop_front());
        chk("w_l_en", ACC_W_IN_L_ENABLE, exp_wl.pop_front());
      end
    end else if (ACC_W_IN_L_ENABLE) unexp("w_l_alone", ACC_W_IN);
    if (ACC_B_IN_ENABLE) begin
      if (exp_b.size() == 0) unexp("b_strobe", ACC_B_IN);
      else chk("b_data", ACC_B_IN, exp_b.pop_front());
    end
    if (ACC_X_IN_ENABLE) begin
      if (exp_x.size() == 0) unexp("x_strobe", ACC_X_IN);
      else chk("x_data", ACC_X_IN, exp_x.pop_front());
    end
    if (M_VALID && M_READY) begin
      if (exp_m.size() == 0) unexp("m_beat", M_DATA);
      else chk("m_data", M_DATA, exp_m.pop_front());
    end
    if (CMD_DONE) begin
      if (exp_done.size() == 0) unexp("cmd_done", {63'd0, CMD_ERROR});
      else chk("done_error", CMD_ERROR, exp_done.pop_front());
    end
    if (ACC_START) start_cnt++;
    if (S_READY) srdy_cnt++;
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic fill(input int base, input int n);
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(DW'(base + k));
  endtask
  task automatic exp_ops(input int x, input int l);
    for (int i = 0; i < l; i++)
      for (int j = 0; j < x; j++) begin
        exp_w.push_back(beats[i*x+j]);
        exp_wl.push_back(j == x - 1);
      end
    for (int k = 0; k < l; k++) exp_b.push_back(beats[l*x+k]);
    for (int k = 0; k < x; k++) exp_x.push_back(beats[l*x+l+k]);
  endtask
  task automatic launch(input int x, input int l, input int y);
    SIZE_X_IN = DW'(x);
    SIZE_L_IN = DW'(l);
    SIZE_Y_IN = DW'(y);
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
  endtask
  task automatic stream(input int n, input bit gap);
    int k = 0, t = 0;
    bit ph = 1'b1;
    while (k < n && t < 400) begin
      S_VALID = gap ? ph : 1'b1;
      S_DATA = beats[k];
      ph = !ph;
      @(negedge CLK);
      if (S_VALID && S_READY) k++;
      tick();
      t++;
    end
    S_VALID = 1'b0;
    if (k < n) unexp("stream_timeout", DW'(k));
  endtask
  task automatic wait_start;
    int t = 0;
    @(negedge CLK);
    while (!ACC_START && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("acc_start_seen", ACC_START, 1);
    tick();
  endtask
  task automatic wait_done;
    int t = 0;
    @(negedge CLK);
    while (!CMD_DONE && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("cmd_done_seen", CMD_DONE, 1);
    tick();
  endtask
  task automatic ypush(input logic [DW-1:0] v);
    ACC_Y_OUT_ENABLE = 1'b1;
    ACC_Y_OUT = v;
    tick();
    ACC_Y_OUT_ENABLE = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s0, r0, lat;
    RST = 1'b0; CMD_START = 1'b0; CMD_ABORT = 1'b0; S_VALID = 1'b0; S_DATA = '0;
    SIZE_X_IN = '0; SIZE_L_IN = '0; SIZE_Y_IN = '0; M_READY = 1'b1; ACC_READY = 1'b1;
    ACC_Y_OUT_ENABLE = 1'b0; ACC_Y_OUT = '0;
    repeat (3) tick();
    @(negedge CLK);
    chk("reset_outputs", any_out, 0);
    RST = 1'b1;
    tick();
    fill(1, 8); exp_ops(2, 2);
    exp_m.push_back('hA); exp_m.push_back('hB); exp_done.push_back(1'b0);
    s0 = start_cnt;
    launch(2, 2, 2); stream(8, 1'b0); wait_start(); ypush('hA); ypush('hB); wait_done();
    chk("basic_start_pulses", DW'(start_cnt - s0), 1);
    exp_done.push_back(1'b1);
    s0 = start_cnt; r0 = srdy_cnt;
    SIZE_X_IN = 2; SIZE_L_IN = 0; SIZE_Y_IN = 1; CMD_START = 1'b1;
    for (lat = 1; lat <= 20; lat++) begin
      tick();
      CMD_START = 1'b0;
      @(negedge CLK);
      if (CMD_DONE) break;
    end
    chk("zero_done_latency", DW'(lat), 2);
    tick();
    chk("zero_start_pulses", DW'(start_cnt - s0), 0);
    chk("zero_s_ready", DW'(srdy_cnt - r0), 0);
    fill(1, 3); exp_ops(1, 1);
    for (int k = 0; k < 8; k++) exp_m.push_back(DW'('h10 + k));
    exp_done.push_back(1'b1);
    launch(1, 1, 8); stream(3, 1'b0); wait_start();
    M_READY = 1'b0;
    for (int k = 0; k < 9; k++) ypush(DW'('h10 + k));
    M_READY = 1'b1;
    wait_done();
    fill(4, 3); exp_ops(1, 1);
    for (int k = 0; k < 9; k++) exp_m.push_back(DW'('h20 + k));
    exp_done.push_back(1'b0);
    launch(1, 1, 9); stream(3, 1'b0); wait_start();
    M_READY = 1'b0;
    for (int k = 0; k < 8; k++) ypush(DW'('h20 + k));
    M_READY = 1'b1;
    ypush('h28);
    wait_done();
    fill(1, 8);
    for (int k = 0; k < 4; k++) begin
      exp_w.push_back(beats[k]);
      exp_wl.push_back(k % 2 == 1);
    end
    exp_b.push_back(beats[4]);
    launch(2, 2, 2); stream(5, 1'b0);
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
    @(negedge CLK);
    chk("abort_busy", CMD_BUSY, 0);
    chk("abort_s_ready", S_READY, 0);
    repeat (4) tick();
    fill('h31, 8); exp_ops(2, 2);
    exp_m.push_back('hC); exp_m.push_back('hD); exp_done.push_back(1'b0);
    s0 = start_cnt;
    launch(2, 2, 2); stream(8, 1'b0); wait_start(); ypush('hC); ypush('hD); wait_done();
    chk("relaunch_start_pulses", DW'(start_cnt - s0), 1);
    fill('h41, 11); exp_ops(3, 2);
    exp_m.push_back('h77); exp_done.push_back(1'b0);
    launch(3, 2, 1); stream(11, 1'b1); wait_start(); ypush('h77); wait_done();
    launch(1, 1, 1);
    RST = 1'b0;
    @(negedge CLK);
    chk("midjob_reset_outputs", any_out, 0);
    tick(); tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("after_reset_busy", CMD_BUSY, 0);
    repeat (5) tick();
    chk("left_w", DW'(exp_w.size()), 0);
    chk("left_b", DW'(exp_b.size()), 0);
    chk("left_x", DW'(exp_x.size()), 0);
    chk("left_m", DW'(exp_m.size()), 0);
    chk("left_done", DW'(exp_done.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accelerator_top_sequencer.md
ACCELERATOR_TOP_SEQUENCER -- requirements
Module: accelerator_top_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, meaning the width of data and size words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of Y result buffer entries (power of 2, >=2).
REQ-003 SHALL have port CLK  in  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports CMD_START in 1 (launch) and CMD_ABORT in 1 (cancel).
REQ-006 SHALL have ports CMD_BUSY out 1 (not IDLE), CMD_DONE out 1 (one-cycle completion pulse) and CMD_ERROR out 1 (valid with CMD_DONE).
REQ-007 SHALL have ports SIZE_X_IN, SIZE_L_IN and SIZE_Y_IN, each in DATA_SIZE, carrying the job dimensions sampled at launch.
REQ-008 SHALL have ports S_DATA in DATA_SIZE, S_VALID in 1 and S_READY out 1, forming the host operand stream.
REQ-009 SHALL have ports M_DATA out DATA_SIZE, M_VALID out 1 and M_READY in 1, forming the result stream.
REQ-010 SHALL have ports ACC_START out 1 and ACC_READY in 1 for the accelerator start/ready handshake.
REQ-011 SHALL have ports ACC_W_IN_L_ENABLE, ACC_W_IN_X_ENABLE, ACC_B_IN_ENABLE and ACC_X_IN_ENABLE, each out 1, as the accelerator load strobes.
REQ-012 SHALL have ports ACC_W_IN, ACC_B_IN and ACC_X_IN, each out DATA_SIZE, as the accelerator operand data.
REQ-013 SHALL have ports ACC_Y_OUT_ENABLE in 1 and ACC_Y_OUT in DATA_SIZE for accelerator result delivery.

Function
REQ-014 SHALL implement states IDLE, LOAD_W, LOAD_B, LOAD_X, RUN, DONE.
REQ-015 SHALL, in IDLE with CMD_START=1, latch the three sizes, clear counters and CMD_ERROR, and enter LOAD_W next cycle.
REQ-016 SHALL, on launch with latched SIZE_X=0 or SIZE_L=0, go directly to DONE with CMD_ERROR=1 and never assert ACC_START.
REQ-017 SHALL ignore CMD_START outside IDLE.
REQ-018 SHALL assert S_READY (registered) only in LOAD_W, LOAD_B and LOAD_X; a beat is accepted when S_VALID and S_READY are both 1.
REQ-019 SHALL, for each accepted beat, register S_DATA onto the phase's ACC_*_IN bus and pulse the phase strobe for exactly the next cycle; strobes are 0 otherwise.
REQ-020 SHALL, in LOAD_W, accept SIZE_L*SIZE_X beats row-major using column counter j (0..SIZE_X-1, wraps) and row counter i.
REQ-021 SHALL, in LOAD_W, assert ACC_W_IN_X_ENABLE on every beat and ACC_W_IN_L_ENABLE only on beats with j=SIZE_X-1.
REQ-022 SHALL, in LOAD_B, accept SIZE_L beats with ACC_B_IN_ENABLE, and in LOAD_X accept SIZE_X beats with ACC_X_IN_ENABLE.
REQ-023 SHALL advance phases on the cycle after the final beat is accepted, and SHALL drop S_READY in that same cycle.
REQ-024 SHALL pulse ACC_START for exactly one cycle on the first cycle of RUN.
REQ-025 SHALL, in RUN, push ACC_Y_OUT into the FIFO on every cycle ACC_Y_OUT_ENABLE=1; the enable is ignored in all other states.
REQ-026 SHALL drive M_VALID=1 whenever the FIFO is non-empty, with M_DATA equal to the FIFO head and a pop on M_VALID and M_READY.
REQ-027 SHALL, when the FIFO is full with a push and no pop in the same cycle, drop the push and set sticky CMD_ERROR; a simultaneous push and pop when full SHALL be legal.
REQ-028 SHALL leave RUN for DONE when ACC_READY has been seen high at least one cycle after ACC_START and SIZE_Y results have been popped.
REQ-029 SHALL stay in DONE for one cycle with CMD_DONE=1, then return to IDLE.
REQ-030 SHALL, on CMD_ABORT=1 in any non-IDLE state, enter IDLE next cycle, flush the FIFO, zero all strobes and emit no CMD_DONE.
REQ-031 SHALL give CMD_ABORT priority over every other transition.
REQ-032 SHALL compare counters at DATA_SIZE width, and SHALL compute SIZE_L*SIZE_X as nested counters without a multiplier.

Reset
REQ-033 SHALL, while RST=0 at a rising edge, enter IDLE, empty the FIFO and clear all counters.
REQ-034 SHALL hold all outputs at 0 during reset, including S_READY, M_VALID, ACC_START, all enables and data buses, and CMD_*.
REQ-035 SHALL, on reset mid-job, abandon the job with no CMD_DONE.

Verification
REQ-036 SHALL cover launch with X=2, L=2, Y=2 and operands 1..8 -> W receives 1,2,3,4 with L_ENABLE on 2 and 4, B receives 5,6, X receives 7,8, one ACC_START pulse, Y results A,B on M, CMD_DONE=1 with CMD_ERROR=0.
REQ-037 SHALL cover launch with SIZE_L=0 -> CMD_DONE with CMD_ERROR=1 two cycles after CMD_START, and no S_READY or ACC_START.
REQ-038 SHALL cover M_READY=0 with FIFO_DEPTH+1 results in RUN -> first 8 results held, 9th dropped, CMD_ERROR=1 at CMD_DONE.
REQ-039 SHALL cover push and pop on the same cycle with the FIFO full -> occupancy unchanged and no error.
REQ-040 SHALL cover CMD_ABORT during LOAD_B after 1 beat -> IDLE next cycle, no further strobes, and a relaunch that executes correctly.
REQ-041 SHALL cover S_VALID toggling every other cycle in LOAD_W -> strobes only after accepted beats and counts exact.
